// File: rtl/soc_irq_timer_pkg.sv
// Shared types and helpers for the soc_irq_timer block.
package soc_irq_timer_pkg;

  // Upper bound on the number of timer channels.
  localparam int MAX_CH = 8;

  // Storage width of the period field. Channels compare against it
  // after zero-extending their own CNT_W-wide counter.
  localparam int PERIOD_W = 32;

  // Per-channel configuration, loaded as a unit by a config write.
  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic                en;
    logic                oneshot;
    logic                level;
  } ch_cfg_t;

  // Channel-select width. Never zero, even for a single channel.
  function automatic int ch_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/soc_irq_timer_ch.sv
// One timer channel: config registers, terminal-count counter, fire
// detection and the pulse/pending output flop.
module soc_irq_timer_ch
  import soc_irq_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    we_i,
  input  ch_cfg_t cfg_i,
  input  logic    ack_i,
  output logic    irq_o
);

  ch_cfg_t          cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             fire;

  // A channel fires in the cycle its counter sits on a nonzero period.
  assign fire = cfg_q.en && (cfg_q.period != '0) &&
                (PERIOD_W'(cnt_q) == cfg_q.period);

  // Next-state: a config write beats everything, then fire, then counting.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves one unassigned
    // (an unassigned path would infer a latch).
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    out_d = 1'b0;
    if (we_i) begin
      cfg_d = cfg_i;
      cnt_d = '0;
      out_d = 1'b0;
    end else if (fire) begin
      cnt_d = '0;
      out_d = 1'b1;  // fire beats a same-cycle ack in level mode
      if (cfg_q.oneshot) cfg_d.en = 1'b0;
    end else begin
      if (cfg_q.en && (cfg_q.period != '0)) cnt_d = cnt_q + CNT_W'(1);
      // Pulse mode drops after one cycle; level mode holds until acked.
      out_d = cfg_q.level && out_q && !ack_i;
    end
  end

  // Channel state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: rst is synchronous; it is sampled on the clock edge like any
    // other input and clears every flop, so a mid-count reset discards all.
    if (rst) begin
      cfg_q <= '0;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so all flops see pre-edge values.
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign irq_o = out_q;

endmodule

// File: rtl/soc_irq_timer.sv
// Periodic/one-shot interrupt generator: NUM_CH timer channels on a slice
// of the irq vector, plus a kickable watchdog and a free-running counter.
module soc_irq_timer
  import soc_irq_timer_pkg::*;
#(
  parameter  int NUM_CH   = 2,
  parameter  int CNT_W    = 16,
  parameter  int IRQ_W    = 32,
  parameter  int IRQ_BASE = 4,
  parameter  int WDT_W    = 20,
  localparam int CH_SEL_W = ch_sel_w(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_SEL_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic                cfg_en,
  input  logic                cfg_oneshot,
  input  logic                cfg_level,
  input  logic [NUM_CH-1:0]   irq_ack,
  output logic [IRQ_W-1:0]    irq,
  input  logic [WDT_W-1:0]    wdt_limit,
  input  logic                wdt_kick,
  output logic                wdt_expired,
  output logic [31:0]         cycle_count
);

  if ((IRQ_BASE + NUM_CH > IRQ_W) || (NUM_CH < 1) || (NUM_CH > MAX_CH) ||
      (CNT_W < 1) || (CNT_W > PERIOD_W)) begin : g_bad_params
    $error("soc_irq_timer: illegal NUM_CH/CNT_W/IRQ_BASE/IRQ_W combination");
  end

  ch_cfg_t           cfg_wr;
  logic [NUM_CH-1:0] ch_irq;
  logic [IRQ_W-1:0]  irq_vec;

  assign cfg_wr = '{period:  PERIOD_W'(cfg_period),
                    en:      cfg_en,
                    oneshot: cfg_oneshot,
                    level:   cfg_level};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    // Out-of-range cfg_ch values match no channel and are ignored.
    assign ch_we = cfg_we && (cfg_ch == CH_SEL_W'(i));

    soc_irq_timer_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .we_i  (ch_we),
      .cfg_i (cfg_wr),
      .ack_i (irq_ack[i]),
      .irq_o (ch_irq[i])
    );
  end

  // Place the channel outputs on their slice; every other bit stays 0.
  always_comb begin
    irq_vec                      = '0;
    irq_vec[IRQ_BASE +: NUM_CH]  = ch_irq;
  end

  assign irq = irq_vec;

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_exp_q, wdt_exp_d;
  logic [31:0]      cyc_q, cyc_d;

  // Watchdog and cycle counter next-state; a kick beats a limit match.
  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    wdt_exp_d = wdt_exp_q;
    cyc_d     = cyc_q + 32'd1;
    if (wdt_kick) begin
      wdt_cnt_d = '0;
    end else if ((wdt_limit != '0) && !wdt_exp_q) begin
      // Counting stops once expired, so the counter saturates.
      wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      if (wdt_cnt_q == wdt_limit) wdt_exp_d = 1'b1;
    end
  end

  // Watchdog and cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt_q <= '0;
      wdt_exp_q <= 1'b0;
      cyc_q     <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      wdt_exp_q <= wdt_exp_d;
      cyc_q     <= cyc_d;
    end
  end

  assign wdt_expired = wdt_exp_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_soc_irq_timer.sv
// Self-checking bench for soc_irq_timer: directed scenarios plus random
// traffic, compared every cycle against an event-time reference model.
module tb_soc_irq_timer;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 16;
  localparam int IRQ_W    = 32;
  localparam int IRQ_BASE = 4;
  localparam int WDT_W    = 20;
  localparam int SEL_W    = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic              cfg_en;
  logic              cfg_oneshot;
  logic              cfg_level;
  logic [NUM_CH-1:0] irq_ack;
  logic [IRQ_W-1:0]  irq;
  logic [WDT_W-1:0]  wdt_limit;
  logic              wdt_kick;
  logic              wdt_expired;
  logic [31:0]       cycle_count;

  always #5 clk = ~clk;

  soc_irq_timer #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .IRQ_W    (IRQ_W),
    .IRQ_BASE (IRQ_BASE),
    .WDT_W    (WDT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_en      (cfg_en),
    .cfg_oneshot (cfg_oneshot),
    .cfg_level   (cfg_level),
    .irq_ack     (irq_ack),
    .irq         (irq),
    .wdt_limit   (wdt_limit),
    .wdt_kick    (wdt_kick),
    .wdt_expired (wdt_expired),
    .cycle_count (cycle_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: channels are tracked by the absolute edge on which
  // their irq next rises, not by a cycle-by-cycle counter.
  longint      edge_n;
  bit          m_en   [NUM_CH];
  int unsigned m_p    [NUM_CH];
  bit          m_os   [NUM_CH];
  bit          m_lv   [NUM_CH];
  longint      m_next [NUM_CH];
  bit          m_irq  [NUM_CH];
  int unsigned m_wc;
  bit          m_wexp;
  logic [31:0] m_cc;

  task automatic model_edge();
    if (rst) begin
      edge_n = 0;
      m_cc   = 0;
      m_wc   = 0;
      m_wexp = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_en[i] = 0; m_p[i] = 0; m_os[i] = 0; m_lv[i] = 0;
        m_next[i] = 0; m_irq[i] = 0;
      end
      return;
    end
    edge_n++;
    m_cc = m_cc + 32'd1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && int'(cfg_ch) == i) begin
        m_en[i]  = cfg_en;
        m_p[i]   = cfg_period;
        m_os[i]  = cfg_oneshot;
        m_lv[i]  = cfg_level;
        m_irq[i] = 0;
        m_next[i] = edge_n + longint'(m_p[i]) + 1;
      end else if (m_en[i] && m_p[i] != 0 && edge_n == m_next[i]) begin
        m_irq[i] = 1;
        if (m_os[i]) m_en[i] = 0;
        else         m_next[i] = m_next[i] + longint'(m_p[i]) + 1;
      end else begin
        m_irq[i] = m_lv[i] && m_irq[i] && !irq_ack[i];
      end
    end
    if (wdt_kick) begin
      m_wc = 0;
    end else if (wdt_limit != 0 && !m_wexp) begin
      if (m_wc == int'(wdt_limit)) m_wexp = 1;
      m_wc = (m_wc + 1) % (1 << WDT_W);
    end
  endtask

  task automatic compare_all();
    logic [IRQ_W-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_CH; i++) e[IRQ_BASE + i] = m_irq[i];
    check("irq_vec", irq, e);
    check("wdt_expired", 32'(wdt_expired), 32'(m_wexp));
    check("cycle_count", cycle_count, m_cc);
  endtask

  // One clock: update the model with the driven inputs, then compare on
  // the falling edge. cfg_we is a single-cycle strobe.
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    cfg_we = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_ch(input int ch, input int p, input bit en,
                          input bit os, input bit lv);
    cfg_we      = 1'b1;
    cfg_ch      = SEL_W'(ch);
    cfg_period  = CNT_W'(p);
    cfg_en      = en;
    cfg_oneshot = os;
    cfg_level   = lv;
    tick();
  endtask

  // Wait (bounded) for irq[bitn] high; returns its edge index or -1.
  task automatic wait_irq(input int bitn, input int budget, output longint at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (irq[bitn]) begin
        at = edge_n;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    longint w, t1, t2;
    int     highs;

    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_en = 1'b0;
    cfg_oneshot = 1'b0; cfg_level = 1'b0; irq_ack = '0;
    wdt_limit = '0; wdt_kick = 1'b0;

    // Reset state.
    do_reset();
    check("reset_irq", irq, 32'h0);
    check("reset_wdt", 32'(wdt_expired), 32'h0);
    check("reset_cycle", cycle_count, 32'h0);

    // Legacy pattern: ch0 P=8191 periodic/pulse written right after reset.
    write_ch(0, 8191, 1, 0, 0);
    w = edge_n;
    wait_irq(IRQ_BASE, 9000, t1);
    check("legacy_first", 32'(t1 - w), 32'd8192);
    tick();
    check("legacy_width", 32'(irq[IRQ_BASE]), 32'd0);
    wait_irq(IRQ_BASE, 9000, t2);
    check("legacy_spacing", 32'(t2 - t1), 32'd8192);

    // One-shot level on ch1, then ack with no refire.
    do_reset();
    write_ch(1, 9, 1, 1, 1);
    w = edge_n;
    wait_irq(IRQ_BASE + 1, 50, t1);
    check("oneshot_rise", 32'(t1 - w), 32'd10);
    run(5);
    check("oneshot_hold", 32'(irq[IRQ_BASE + 1]), 32'd1);
    irq_ack = 2'b10;
    tick();
    irq_ack = '0;
    check("oneshot_ack", 32'(irq[IRQ_BASE + 1]), 32'd0);
    highs = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (irq[IRQ_BASE + 1]) highs++;
    end
    check("oneshot_norefire", 32'(highs), 32'd0);

    // Fire/ack collision: ack held, level P=3 -> high one cycle in four.
    do_reset();
    write_ch(0, 3, 1, 0, 1);
    irq_ack = 2'b01;
    highs = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (irq[IRQ_BASE]) highs++;
    end
    irq_ack = '0;
    check("collision_highs", 32'(highs), 32'd10);

    // Rewrite mid-count: P=100, rewritten at count 50 with P=10.
    do_reset();
    write_ch(0, 100, 1, 0, 0);
    run(50);
    write_ch(0, 10, 1, 0, 0);
    w = edge_n;
    wait_irq(IRQ_BASE, 200, t1);
    check("rewrite_gap", 32'(t1 - w), 32'd11);

    // Watchdog: periodic kicks keep it quiet, then expiry 21 cycles later.
    do_reset();
    wdt_limit = WDT_W'(20);
    for (int r = 0; r < 8; r++) begin
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
      run(14);
    end
    check("wdt_no_expiry", 32'(wdt_expired), 32'd0);
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    w = edge_n;
    t1 = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (wdt_expired) begin
        t1 = edge_n;
        break;
      end
    end
    check("wdt_latency", 32'(t1 - w), 32'd21);
    for (int r = 0; r < 3; r++) begin
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
      run(4);
    end
    check("wdt_sticky", 32'(wdt_expired), 32'd1);
    do_reset();
    check("wdt_reset_clear", 32'(wdt_expired), 32'd0);

    // Kick in the match cycle wins; the next match flags.
    run(20);
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    check("wdt_kick_wins", 32'(wdt_expired), 32'd0);
    run(21);
    check("wdt_after_kick", 32'(wdt_expired), 32'd1);

    // Limit 0 disables the watchdog.
    do_reset();
    wdt_limit = '0;
    run(100);
    check("wdt_disabled", 32'(wdt_expired), 32'd0);

    // Reset mid-operation while irq is high and counters are running.
    write_ch(1, 5, 1, 0, 1);
    write_ch(0, 7, 1, 0, 0);
    wait_irq(IRQ_BASE + 1, 50, t1);
    run(2);
    check("midrst_pre", 32'(irq[IRQ_BASE + 1]), 32'd1);
    do_reset();
    check("midrst_irq", irq, 32'h0);
    check("midrst_cycle", cycle_count, 32'h0);
    highs = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (irq != '0) highs++;
    end
    check("midrst_disabled", 32'(highs), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 7) == 0) begin
        cfg_we      = 1'b1;
        cfg_ch      = SEL_W'($urandom_range(0, NUM_CH - 1));
        cfg_period  = ($urandom_range(0, 9) == 0) ? '0
                                                  : CNT_W'($urandom_range(1, 12));
        cfg_en      = ($urandom_range(0, 4) != 0);
        cfg_oneshot = 1'($urandom_range(0, 1));
        cfg_level   = 1'($urandom_range(0, 1));
      end
      irq_ack  = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      wdt_kick = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) begin
        wdt_limit = ($urandom_range(0, 3) == 0) ? '0
                                                : WDT_W'($urandom_range(1, 40));
        wdt_kick  = 1'b1;
      end
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
